decrypt_pipe_encode: RTL

DECRYPT_PIPE_ENCODE -- requirements
Module: decrypt_pipe_encode

---
 rtl/decrypt_pipe_encode.sv | 73 +++++++
 1 files changed

// File: rtl/decrypt_pipe_encode.sv
// decrypt_pipe_encode: classifies ASCII input, applies a rotating 3-key letter shift as a one-hot word,
// and registers everything with one cycle of latency for the downstream shift stage.
module decrypt_pipe_encode (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mode,
    input  logic        restart,
    input  logic [7:0]  din,
    input  logic [7:0]  k1,
    input  logic [7:0]  k2,
    input  logic [7:0]  k3,
    input  logic [2:0]  rot_freq,
    output logic        en_out,
    output logic [7:0]  data_out,
    output logic [31:0] extended_out,
    output logic        shift_en,
    output logic [2:0]  shift_amt,
    output logic        is_alpha_upper_case,
    output logic        is_alpha_low_case
);
    logic [1:0] key_sel, ks;
    logic [2:0] cnt, ct, key;
    logic       upper, lower, active;
    logic [4:0] idx, rot;
    logic [5:0] pos;

    // restart forces this character onto k1 with a fresh rotation count
    always_comb begin
        upper  = din >= 8'd65 && din <= 8'd90;
        lower  = din >= 8'd97 && din <= 8'd122;
        active = en & mode & (upper | lower);
        ks     = restart ? 2'd0 : key_sel;
        ct     = restart ? 3'd0 : cnt;
        key    = ks == 2'd0 ? k1[2:0] : ks == 2'd1 ? k2[2:0] : k3[2:0];
        idx    = upper ? 5'(din - 8'd65) : 5'(din - 8'd97);
        pos    = {1'b0, idx} + {3'b0, key};
        rot    = pos >= 6'd26 ? 5'(pos - 6'd26) : pos[4:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sel <= 2'd0;
            cnt     <= 3'd0;
        end else if (active) begin
            cnt     <= ct == rot_freq ? 3'd0 : ct + 3'd1;
            key_sel <= ct != rot_freq ? ks : ks == 2'd2 ? 2'd0 : ks + 2'd1;
        end else begin
            cnt     <= ct;
            key_sel <= ks;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out              <= 1'b0;
            data_out            <= 8'd0;
            extended_out        <= 32'd0;
            shift_en            <= 1'b0;
            shift_amt           <= 3'd0;
            is_alpha_upper_case <= 1'b0;
            is_alpha_low_case   <= 1'b0;
        end else begin
            en_out              <= en;
            data_out            <= din;
            extended_out        <= active ? 32'd1 << rot : en ? {24'd0, din} : 32'd0;
            shift_en            <= active && key != 3'd0;
            shift_amt           <= active ? key : 3'd0;
            is_alpha_upper_case <= active & upper;
            is_alpha_low_case   <= active & lower;
        end
    end
endmodule
